// File: rtl/cnn_accel_pkg.sv
// Shared constants and types for the CNN accelerator read DMA.
// AXI encodings, the DMA state enum and the descriptor record.
package cnn_accel_pkg;
  localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         RD_ADDR_W      = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } rd_dma_state_t;

  typedef struct packed {
    logic [RD_ADDR_W-1:0] addr;
    logic [15:0]          beats;
  } rd_desc_t;
endpackage

// File: rtl/cnn_axi_rd_dma_if.sv
// Descriptor, AXI read and output stream signals of the read DMA.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1; valid never waits on ready.
interface cnn_axi_rd_dma_if #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 128
);
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [15:0]       desc_beats;

  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  desc_valid, desc_addr, desc_beats,
    output desc_ready,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    output desc_valid, desc_addr, desc_beats,
    input  desc_ready,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/cnn_sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible whenever valid=1.
// Power-of-two depth so pointers wrap naturally; count feeds the DMA space check.
module cnn_sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A push at full is accepted when a pop frees the head in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign valid    = (count != '0);
endmodule

// File: rtl/cnn_axi_rd_dma.sv
// AXI4 INCR read DMA: one descriptor in, 4 KB-safe bursts out, ordered 128-bit stream to compute.
// CNN_RD_DMA_CHK_EN enables R-channel beat counting and the sticky err flag.
module cnn_axi_rd_dma
  import cnn_accel_pkg::*;
#(
  parameter int ADDR_W     = RD_ADDR_W,
  parameter int DATA_W     = 128,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_b,
  cnn_axi_rd_dma_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output rd_dma_state_t           state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_desc_t          cur;
  logic [15:0]       total, push_idx;
  logic              desc_zero, desc_ready_q;
  logic              arvalid_q, rready_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [8:0]        to_bound, len;
  logic              space_ok, r_push, burst_end, beat_last, pop;
  logic [DATA_W:0]   fifo_q;
  logic              fifo_valid;
  logic [CW-1:0]     fifo_count;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.desc_addr[3:0];

  // Burst length: min(remaining, MAX_BURST, beats left in this 4 KB page).
  assign to_bound = 9'd256 - {1'b0, cur.addr[11:4]};
  always_comb begin
    len = (cur.beats > 16'(MAX_BURST)) ? 9'(MAX_BURST) : cur.beats[8:0];
    if (len > to_bound) len = to_bound;
  end

  assign space_ok  = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(len);
  assign r_push    = bus.m_axi_rvalid && rready_q;
  assign beat_last = (push_idx == total - 16'd1);
  assign pop       = fifo_valid && bus.out_ready;

`ifdef CNN_RD_DMA_CHK_EN
  logic [7:0] beat_cnt;
  assign burst_end = r_push && (beat_cnt == arlen_q);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ISSUE)  beat_cnt <= '0;
      else if (r_push)     beat_cnt <= beat_cnt + 1'b1;
      if (r_push && (bus.m_axi_rlast != (beat_cnt == arlen_q))) err <= 1'b1;
      if (bus.m_axi_rvalid && !rready_q)                        err <= 1'b1;
    end
  end
`else
  assign burst_end = r_push && bus.m_axi_rlast;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      cur          <= '0;
      total        <= '0;
      push_idx     <= '0;
      desc_zero    <= 1'b0;
      desc_ready_q <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      rready_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (desc_ready_q && bus.desc_valid) begin
            desc_ready_q <= 1'b0;
            cur.addr     <= RD_ADDR_W'({bus.desc_addr[ADDR_W-1:4], 4'b0000});
            cur.beats    <= bus.desc_beats;
            total        <= bus.desc_beats;
            push_idx     <= '0;
            desc_zero    <= (bus.desc_beats == 16'd0);
            state        <= (bus.desc_beats == 16'd0) ? DRAIN : ISSUE;
          end else begin
            desc_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          // cur is frozen until the AR handshake, so araddr/arlen stay stable.
          if (!arvalid_q) begin
            if (space_ok) begin
              arvalid_q <= 1'b1;
              araddr_q  <= ADDR_W'(cur.addr);
              arlen_q   <= 8'(len - 9'd1);
            end
          end else if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cur.addr  <= cur.addr + RD_ADDR_W'({len, 4'b0000});
            cur.beats <= cur.beats - 16'(len);
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_push) begin
            push_idx <= push_idx + 16'd1;
            if (burst_end) begin
              rready_q <= 1'b0;
              state    <= (cur.beats == 16'd0) ? DRAIN : ISSUE;
            end
          end
        end
        DRAIN: begin
          if (done) begin
            state        <= IDLE;
            desc_zero    <= 1'b0;
            desc_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cnn_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (r_push),
    .push_data ({beat_last, bus.m_axi_rdata}),
    .pop       (pop),
    .pop_data  (fifo_q),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // Only the final word carries last, so its pop in DRAIN ends the descriptor.
  assign done = (state == DRAIN) && (desc_zero || (pop && fifo_q[DATA_W]));
  assign busy = (state != IDLE);

  assign bus.desc_ready    = desc_ready_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = AXI_SIZE_16B;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign bus.out_valid     = fifo_valid;
  assign bus.out_data      = fifo_valid ? fifo_q[DATA_W-1:0] : '0;
  assign bus.out_last      = fifo_valid && fifo_q[DATA_W];
endmodule
